// File: rtl/sync_mem_2p_clr.sv
// Simple-dual-port synchronous memory with a registered read port and a clear engine.
// Optional per-entry even parity is enabled by defining MEM_PARITY_EN.
module sync_mem_2p_clr #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 4,
  parameter int               RDW_MODE = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [DEPTH-1:0] wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic             re,
  input  logic [DEPTH-1:0] rdAddr,
  output logic [WIDTH-1:0] rdData,
  output logic             rdValid,
  input  logic             clr,
  output logic             busy,
  output logic             parErr,
  output logic [0:0]       dbgState
);

  localparam int NDEPTH = 1 << DEPTH;
`ifdef MEM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  localparam logic [0:0] SWEEP = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  logic [0:0]       state;
  logic [DEPTH-1:0] cnt;
  logic [MW-1:0]    mem [NDEPTH];

  logic             idle;
  logic             wrEn;
  logic             rdHit;
  logic [DEPTH-1:0] memAddr;
  logic [WIDTH-1:0] memData;
  logic [MW-1:0]    wrWord;
  logic [MW-1:0]    rdWord;

  // Handshake: a read is accepted on any edge where re=1 while idle and clr=0;
  // rdValid then pulses for exactly one cycle with the new rdData. No backpressure.
  assign idle  = (state == IDLE);
  assign busy  = ~idle;
  assign wrEn  = ~idle | (we & ~clr);
  assign rdHit = idle & re & ~clr;
  assign dbgState = state;

  always_comb begin
    memAddr = idle ? wrAddr : cnt;
    memData = idle ? wrData : INIT_VAL;
  end

`ifdef MEM_PARITY_EN
  assign wrWord = {^memData, memData};
`else
  assign wrWord = memData;
`endif

  always_comb begin
    rdWord = mem[rdAddr];
    if (RDW_MODE == 1 && we && wrAddr == rdAddr) rdWord = wrWord;
  end

  // The array has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && wrEn) mem[memAddr] <= wrWord;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SWEEP;
      cnt   <= '0;
    end else if (!idle) begin
      cnt <= cnt + 1'b1;
      if (cnt == DEPTH'(NDEPTH - 1)) state <= IDLE;
    end else if (clr) begin
      state <= SWEEP;
      cnt   <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdData  <= '0;
      rdValid <= 1'b0;
    end else begin
      rdValid <= rdHit;
      if (rdHit) rdData <= rdWord[WIDTH-1:0];
    end
  end

`ifdef MEM_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parErr <= 1'b0;
    else if (rdHit) parErr <= (rdWord[WIDTH] != ^rdWord[WIDTH-1:0]);
  end
`else
  assign parErr = 1'b0;
`endif

endmodule

// File: tb/tb_sync_mem_2p_clr.sv
// Directed self-checking bench for sync_mem_2p_clr: read-old and write-first
// instances driven in lockstep from the same stimulus.
module tb_sync_mem_2p_clr;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic [3:0] wrAddr = '0;
  logic [7:0] wrData = '0;
  logic       re = 1'b0;
  logic [3:0] rdAddr = '0;
  logic       clr = 1'b0;

  logic [7:0] rdData0, rdData1;
  logic       rdValid0, rdValid1, busy0, busy1, parErr0, parErr1;
  logic [0:0] dbgState0, dbgState1;

  int nChecks = 0;
  int nFails  = 0;
  int n;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sync_mem_2p_clr #(.WIDTH(8), .DEPTH(4), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .wrAddr(wrAddr), .wrData(wrData),
    .re(re), .rdAddr(rdAddr), .rdData(rdData0), .rdValid(rdValid0),
    .clr(clr), .busy(busy0), .parErr(parErr0), .dbgState(dbgState0)
  );

  sync_mem_2p_clr #(.WIDTH(8), .DEPTH(4), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .we(we), .wrAddr(wrAddr), .wrData(wrData),
    .re(re), .rdAddr(rdAddr), .rdData(rdData1), .rdValid(rdValid1),
    .clr(clr), .busy(busy1), .parErr(parErr1), .dbgState(dbgState1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeMem(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; wrAddr = a; wrData = d;
    step();
    we = 1'b0;
  endtask

  // Expected values for the read-old and write-first instances go through exp_q.
  task automatic readBoth(input string tag, input logic [3:0] a, input logic [7:0] e0, input logic [7:0] e1);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    re = 1'b1; rdAddr = a;
    step();
    re = 1'b0;
    check({tag, "_v0"}, rdValid0, 1);
    check({tag, "_v1"}, rdValid1, 1);
    check({tag, "_d0"}, rdData0, exp_q.pop_front());
    check({tag, "_d1"}, rdData1, exp_q.pop_front());
  endtask

  // Counts edges until both instances leave the sweep; reads/writes/clr stay asserted
  // on the listed cycles to prove they are ignored.
  task automatic waitIdle(input string tag, input int clrAt, output int cnt);
    cnt = 0;
    while ((busy0 || busy1) && cnt < 40) begin
      we = 1'b1; wrAddr = 4'd0; wrData = 8'h77;
      re = 1'b1; rdAddr = 4'd0;
      clr = (cnt == clrAt);
      step();
      cnt++;
      if (busy0) check({tag, "_noValid"}, rdValid0, 0);
    end
    we = 1'b0; re = 1'b0; clr = 1'b0;
    if (cnt >= 40) check({tag, "_timeout"}, cnt, 16);
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_busy", busy0, 1);
    check("rst_rdData", rdData0, 0);
    check("rst_rdValid", rdValid0, 0);
    check("rst_parErr", parErr0, 0);

    // Initial sweep: exactly 16 edges after release
    rst = 1'b1;
    waitIdle("initSweep", -1, n);
    check("initSweep_len", n, 16);
    check("initSweep_busy1", busy1, 0);
    for (int i = 0; i < 16; i++) readBoth($sformatf("init_rd%0d", i), 4'(i), 8'h00, 8'h00);

    // Basic write/read, then hold with re=0
    writeMem(4'd3, 8'hA5);
    readBoth("wr3", 4'd3, 8'hA5, 8'hA5);
    step();
    check("hold_valid", rdValid0, 0);
    check("hold_data", rdData0, 8'hA5);

    // Read-during-write on the same address
    writeMem(4'd5, 8'h11);
    we = 1'b1; wrAddr = 4'd5; wrData = 8'h22;
    readBoth("rdw", 4'd5, 8'h11, 8'h22);
    we = 1'b0;
    readBoth("rdw_after", 4'd5, 8'h22, 8'h22);

    // Different addresses are independent
    we = 1'b1; wrAddr = 4'd6; wrData = 8'h33;
    readBoth("diffAddr", 4'd7, 8'h00, 8'h00);
    we = 1'b0;
    readBoth("diffAddr_wr", 4'd6, 8'h33, 8'h33);

    // Fill with 0xFF, then clear; a second clr mid-sweep must not extend it
    for (int i = 0; i < 16; i++) writeMem(4'(i), 8'hFF);
    readBoth("fill15", 4'd15, 8'hFF, 8'hFF);
    clr = 1'b1; re = 1'b1; rdAddr = 4'd3; we = 1'b1; wrAddr = 4'd3; wrData = 8'h99;
    step();
    clr = 1'b0; re = 1'b0; we = 1'b0;
    check("clr_busy", busy0, 1);
    check("clr_noValid", rdValid0, 0);
    check("clr_holdData", rdData0, 8'hFF);
    waitIdle("clrSweep", 4, n);
    check("clrSweep_len", n, 16);
    for (int i = 0; i < 16; i++) readBoth($sformatf("clr_rd%0d", i), 4'(i), 8'h00, 8'h00);

    // Reset mid-sweep
    writeMem(4'd2, 8'h5A);
    readBoth("pre_rst", 4'd2, 8'h5A, 8'h5A);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (7) step();
    check("midSweep_hold", rdData0, 8'h5A);
    rst = 1'b0;
    #1;
    check("midRst_busy", busy0, 1);
    check("midRst_rdData", rdData0, 0);
    check("midRst_rdData1", rdData1, 0);
    check("midRst_rdValid", rdValid0, 0);
    step();
    rst = 1'b1;
    waitIdle("rstSweep", -1, n);
    check("rstSweep_len", n, 16);
    readBoth("post_rst2", 4'd2, 8'h00, 8'h00);

`ifdef MEM_PARITY_EN
    writeMem(4'd9, 8'h3C);
    readBoth("par_clean", 4'd9, 8'h3C, 8'h3C);
    check("par_clean_err", parErr0, 0);
    #2;
    dut0.mem[9][0] = ~dut0.mem[9][0];
    readBoth("par_bad", 4'd9, 8'h3D, 8'h3C);
    check("par_bad_err0", parErr0, 1);
    check("par_bad_err1", parErr1, 0);
    readBoth("par_other", 4'd3, 8'h00, 8'h00);
    check("par_other_err", parErr0, 0);
`else
    writeMem(4'd9, 8'h3C);
    readBoth("nopar", 4'd9, 8'h3C, 8'h3C);
    check("nopar_err0", parErr0, 0);
    check("nopar_err1", parErr1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sync_mem_2p_clr.md
# sync_mem_2p_clr

Parametrised simple-dual-port synchronous memory with one write port and one registered read port. A built-in clear engine sweeps every entry to a programmable value after reset and on request. It supersedes the single-port async/sync memories as the team's general storage primitive. Selectable read-during-write behaviour and optional per-entry parity are included.

## Interface
Parameters:
- WIDTH, 8, data bits per entry (≥1)
- DEPTH, 4, address bits; entry count NDEPTH = 1<<DEPTH (local, derived)
- RDW_MODE, 0, same-address read-during-write: 0 = read-old, 1 = write-first
- INIT_VAL, {WIDTH{1'b0}}, value written by the clear engine

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- we  in  1  write enable
- wrAddr  in  DEPTH  write address
- wrData  in  WIDTH  write data
- re  in  1  read enable
- rdAddr  in  DEPTH  read address
- rdData  out  WIDTH  registered read data
- rdValid  out  1  rdData updated this cycle by an accepted read
- clr  in  1  start clear sweep (single-cycle pulse, level also accepted)
- busy  out  1  clear sweep in progress; ports ignored
- parErr  out  1  parity mismatch on current rdData (see Configuration)

## Operation
- FSM states: SWEEP, IDLE.
- Reset (rst=0): state=SWEEP, sweep counter=0, rdData=0, rdValid=0, busy=1, parErr=0. The array is not reset.
- SWEEP: each cycle writes INIT_VAL to mem[counter] and increments the counter. When counter==NDEPTH-1 is written, the FSM goes to IDLE on that edge. busy=1 throughout. we, re and clr are ignored; rdValid=0.
- IDLE: busy=0.
  - we=1 writes wrData to mem[wrAddr].
  - re=1 latches mem[rdAddr] into rdData.
  - clr=1 enters SWEEP with counter=0. we and re in the same cycle are ignored.
- Read-during-write with the same address (we=re=1, wrAddr==rdAddr):
  - RDW_MODE=0: rdData = prior content.
  - RDW_MODE=1: rdData = wrData.
  - Different addresses are independent.
- rdData holds its last value when re=0 or busy=1.
- Address width is exactly DEPTH. There is no out-of-range case, and the sweep counter wraps only at terminal.

## Timing
- Write latency: data is visible to a read issued the next cycle (or the same cycle when RDW_MODE=1).
- Read latency: 1 cycle. re at edge N gives rdData/rdValid valid after edge N. rdValid is a one-cycle pulse per accepted read.
- Sweep duration: exactly NDEPTH cycles from the first rising edge with rst=1, or from the edge after clr is sampled. busy falls after the NDEPTH-th edge.
- Reset asserted mid-sweep or mid-read: immediately returns to reset values. The sweep restarts from 0 after release, and any partial sweep is discarded.
- clr while busy: ignored. The sweep does not restart.

## Configuration
- MEM_PARITY_EN defined:
  - Each entry stores WIDTH+1 bits; the extra bit is the even parity of the data, computed on every write, including sweep writes.
  - On an accepted read, parErr is registered alongside rdData as 1 when the stored parity ≠ ^stored data.
  - parErr is cleared to 0 on reset and holds with rdData.
- MEM_PARITY_EN undefined:
  - No parity storage.
  - parErr is tied to 0.

## Test plan
All scenarios use WIDTH=8, DEPTH=4 (16 entries).
- Release rst -> busy=1 for exactly 16 cycles, then 0. Reads of addresses 0..15 all return 0x00 with rdValid one cycle after each re.
- Idle: write 0xA5 to addr 3, then re with rdAddr=3 next cycle -> rdData=0xA5 and rdValid=1 for one cycle. we during busy does not modify memory.
- Read-during-write on the same address: mem[5]=0x11, then same-cycle we (0x22 to addr 5) and re (addr 5):
  - RDW_MODE=0 -> rdData=0x11; a following read returns 0x22.
  - RDW_MODE=1 -> rdData=0x22.
- Clear sweep: fill all entries with 0xFF, pulse clr -> busy for 16 cycles and all entries read INIT_VAL. A second clr during the sweep does not extend busy beyond 16 cycles.
- Reset mid-sweep: assert rst at sweep cycle 7 -> rdData=0, rdValid=0, busy=1 immediately. After release, busy lasts a full 16 cycles.
- With MEM_PARITY_EN: write 0x3C to addr 9, flip one stored data bit hierarchically, read addr 9 -> parErr=1 with rdValid. Clean entries give parErr=0.
